// File: rtl/store_merge_unit.sv
// rtl/store_merge_unit.sv - word/halfword/byte store unit with read-modify-write merge
//
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   start           request, sampled only while idle
//   addr, wdata     store byte address and source value (store data in low bits)
//   size            00 word, 01 byte, 10 halfword, 11 illegal
//   busy            high whenever the unit is not idle
//   done            one-cycle completion pulse
//   misaligned      one-cycle error pulse, coincident with done
//   mem_addr        word-aligned memory address, held from RD through WR
//   mem_rd, mem_wr  memory read / write strobes
//   mem_rdata       memory read data, valid MEM_LAT cycles after the read strobe
//   mem_wdata       merged write data
module store_merge_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        size,
  output logic              busy,
  output logic              done,
  output logic              misaligned,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_wdata
);

  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int LANES = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, ERR} state_t;

  state_t            state;
  state_t            accept_next;
  logic [OFF_W-1:0]  off_in;
  logic [OFF_W-1:0]  off_q;
  logic [1:0]        size_q;
  logic [15:0]       src_q;
  logic [3:0]        wait_cnt;
  logic [DATA_W-1:0] merged;

  assign off_in = addr[OFF_W-1:0];

  // Where an accepted request goes next, decided from the live inputs in the
  // same cycle they are latched.
  always_comb begin
    accept_next = RD;
    case (size)
      2'b11:   accept_next = ERR;
      2'b10:   if (off_in[0]) accept_next = ERR;
      2'b00:   accept_next = (off_in == '0) ? WR : ERR;
      default: accept_next = RD;
    endcase
  end

  // Lane merge over the incoming memory word. Only byte and halfword requests
  // reach WAIT, and halfwords are always even-aligned, so off_q+1 never wraps.
  always_comb begin
    merged = mem_rdata;
    for (int k = 0; k < LANES; k++) begin
      if (off_q == OFF_W'(k))
        merged[8*k +: 8] = src_q[7:0];
      else if (size_q == 2'b10 && (off_q + OFF_W'(1)) == OFF_W'(k))
        merged[8*k +: 8] = src_q[15:8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      wait_cnt   <= '0;
      off_q      <= '0;
      size_q     <= '0;
      src_q      <= '0;
    end else begin
      // Strobes and pulses are one cycle by default; each state re-arms its own.
      done       <= 1'b0;
      misaligned <= 1'b0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            off_q    <= off_in;
            size_q   <= size;
            src_q    <= wdata[15:0];
            mem_addr <= {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            busy     <= 1'b1;
            state    <= accept_next;
            case (accept_next)
              WR: begin
                mem_wdata <= wdata;
                mem_wr    <= 1'b1;
                done      <= 1'b1;
              end
              ERR: begin
                done       <= 1'b1;
                misaligned <= 1'b1;
              end
              default: mem_rd <= 1'b1;
            endcase
          end
        end
        RD: begin
          wait_cnt <= 4'(MEM_LAT - 1);
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            mem_wdata <= merged;
            mem_wr    <= 1'b1;
            done      <= 1'b1;
            state     <= WR;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        WR, ERR: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/store_merge_unit.md
# store_merge_unit

Parametrised, sequential store unit for the multicycle datapath. It handles word, halfword and byte stores to a word-organised memory, accepting any legal byte offset. Sub-word stores run as a read-modify-write: read the containing word, merge the source lanes, write the word back. Word stores skip the read. The unit sits between the B register and memory, under a start/done handshake from the control unit, and flags misaligned stores instead of performing them.

## Interface
- DATA_W, 32: memory word width; legal values 32 or 64.
- ADDR_W, 32: byte-address width.
- MEM_LAT, 1: cycles from the mem_rd cycle to the cycle in which mem_rdata is valid; legal range 1..8.
- Derived OFF_W = log2(DATA_W/8): number of byte-offset bits.

- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- addr  in  ADDR_W  store byte address.
- wdata  in  DATA_W  source register value; the store data sits in its low bits.
- size  in  2  store size: 00 word, 01 byte, 10 halfword, 11 illegal.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle completion pulse.
- misaligned  out  1  one-cycle error pulse, coincident with done.
- mem_addr  out  ADDR_W  word-aligned address: addr with its low OFF_W bits zeroed.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_rdata  in  DATA_W  memory read data.
- mem_wdata  out  DATA_W  merged write data.

## Operation
- States: IDLE, RD, WAIT, WR, ERR.
- **Accept.** In IDLE with start=1, the unit latches addr, wdata and size, then decodes the request.
- **Decode.** off = latched addr[OFF_W-1:0].
  - size=11 goes to ERR.
  - Halfword with off[0]=1 goes to ERR.
  - Word with off≠0 goes to ERR.
  - Word with off=0 goes to WR.
  - Otherwise (legal byte or halfword) goes to RD.
- **RD.** One cycle: mem_rd=1 and mem_addr valid. Next state is WAIT.
- **WAIT.** Lasts MEM_LAT cycles, tracked by a down-counter.
  - At the clock edge ending the last WAIT cycle, mem_rdata is captured into the merge register.
  - Next state is WR.
- **Merge** (little-endian; lane k = bits [8k+7:8k]).
  - Byte: lane off ← wdata[7:0].
  - Halfword: lanes off and off+1 ← wdata[15:0].
  - All other lanes keep their captured memory value.
  - Word: mem_wdata = wdata.
- **WR.** One cycle: mem_wr=1, done=1, mem_wdata merged. Next state is IDLE.
- **ERR.** One cycle: done=1, misaligned=1, mem_rd=mem_wr=0. Next state is IDLE.
- **Strobes.** mem_rd and mem_wr are never high in the same cycle, and never outside RD and WR respectively.
- **Address hold.** mem_addr is held stable from RD through WR.
- **Busy behaviour.** start is ignored while busy=1. Latched operands do not change while busy=1, whatever the inputs do.
- **Reset.** Reset asserted in any state forces IDLE immediately (asynchronously). An in-flight write is dropped and mem_wr must not assert for it. After reset deasserts, the next start is handled normally.
- **Reset values.** busy=0, done=0, misaligned=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, WAIT counter=0.

## Timing
- Cycle 0 is the IDLE cycle in which start=1 is sampled.
- Word store: WR in cycle 1. Latency 1; no read is issued.
- Byte or halfword store:
  - RD in cycle 1.
  - WAIT in cycles 2..MEM_LAT+1; mem_rdata must be valid in cycle MEM_LAT+1.
  - WR and done in cycle MEM_LAT+2.
- Error: ERR in cycle 1. Latency 1.
- Back-to-back: busy falls in the cycle after WR or ERR. A start sampled in that cycle is accepted, giving a minimum of 1 idle cycle between operations.
- done and misaligned are registered, decoded from state, and never last longer than one cycle.

## Test plan
Unless noted, DATA_W=32 and MEM_LAT=1.

1. **Word store.** addr=0x100, wdata=0xDEADBEEF, size=00 → cycle 1: mem_wr=1, mem_addr=0x100, mem_wdata=0xDEADBEEF, done=1; mem_rd never asserts.
2. **Byte store, top lane.** addr=0x103, wdata=0x123456A5, size=01, memory returns 0x11223344 → mem_rd in cycle 1 with mem_addr=0x100; cycle 3: mem_wr=1, mem_wdata=0xA5223344.
3. **Halfword store, upper half.** addr=0x202, wdata=0x0000CAFE, size=10, memory returns 0x11223344 → cycle 3: mem_addr=0x200, mem_wdata=0xCAFE3344.
4. **Error cases.**
   - Halfword addr=0x201 → cycle 1: done=1, misaligned=1; no mem_rd or mem_wr.
   - Repeat with size=11 and with a word store to addr=0x102: same response.
5. **Longer latency, start while busy.** MEM_LAT=3, byte store addr=0x101, wdata=0x7F, memory 0xAABBCCDD valid in cycle 4 → cycle 5: mem_wdata=0xAABB7FDD. A second start pulsed in cycle 2 is ignored; busy stays 1 through cycle 5.
6. **Reset mid-operation.** Assert reset during WAIT → all outputs go to 0 immediately and no mem_wr follows. After deassertion, a word store with addr=0x0 and wdata=0x1 completes in 1 cycle.
